conv_sequencer: RTL and testbench

- Sequences one 3x3, stride-1, no-padding convolution over the fixed 4x4 input / 3x3 filter operand set that sits in the team's register-file memory block.
- Produces 4 output pixels (2x2) using a single time-shared 8x8 multiply-accumulate unit, one tap per cycle.
- Sits between that register bank and downstream result consumers (display/UART/checker).
- Handshakes are start/busy/done on the command side and valid/ready on the result side.

---
 rtl/conv_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_conv_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_sequencer.sv
// Time-shared 3x3 convolution sequencer over a latched 4x4 image, one MAC tap per cycle.
// Optional `CONV_STALL_CNT_EN adds a saturating output-backpressure counter (stall_cnt).
module conv_sequencer #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [16*DATA_W-1:0] in_flat,
  input  logic [9*DATA_W-1:0]  filt_flat,
  output logic                 busy,
  output logic                 done,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [ACC_W-1:0]     result_data,
  output logic [1:0]           result_idx
`ifdef CONV_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_MAC  = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [3:0]            tap_q, tap_d;
  logic [1:0]            win_q, win_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [16*DATA_W-1:0]  in_q, in_d;
  logic [9*DATA_W-1:0]   filt_q, filt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  valid_q, valid_d;
  logic [ACC_W-1:0]      data_q, data_d;
  logic [1:0]            idx_q, idx_d;

  logic [DATA_W-1:0]     in_arr_s [16];
  logic [DATA_W-1:0]     filt_arr_s [9];
  logic [1:0]            tap_i_s, tap_j_s;
  logic [1:0]            row_s, col_s;
  logic [3:0]            pix_idx_s;
  logic [2*DATA_W-1:0]   prod_s;
  logic [ACC_W-1:0]      prod_ext_s;

  // Operand unpacking and the single shared multiplier for the current tap.
  always_comb begin
    for (int k = 0; k < 16; k++) in_arr_s[k] = in_q[k*DATA_W +: DATA_W];
    for (int t = 0; t < 9; t++) filt_arr_s[t] = filt_q[t*DATA_W +: DATA_W];
    case (tap_q)
      4'd0:    begin tap_i_s = 2'd0; tap_j_s = 2'd0; end
      4'd1:    begin tap_i_s = 2'd0; tap_j_s = 2'd1; end
      4'd2:    begin tap_i_s = 2'd0; tap_j_s = 2'd2; end
      4'd3:    begin tap_i_s = 2'd1; tap_j_s = 2'd0; end
      4'd4:    begin tap_i_s = 2'd1; tap_j_s = 2'd1; end
      4'd5:    begin tap_i_s = 2'd1; tap_j_s = 2'd2; end
      4'd6:    begin tap_i_s = 2'd2; tap_j_s = 2'd0; end
      4'd7:    begin tap_i_s = 2'd2; tap_j_s = 2'd1; end
      4'd8:    begin tap_i_s = 2'd2; tap_j_s = 2'd2; end
      default: begin tap_i_s = 2'd0; tap_j_s = 2'd0; end
    endcase
    row_s      = {1'b0, win_q[1]} + tap_i_s;
    col_s      = {1'b0, win_q[0]} + tap_j_s;
    pix_idx_s  = {row_s, col_s};
    prod_s     = {{DATA_W{1'b0}}, in_arr_s[pix_idx_s]} * {{DATA_W{1'b0}}, filt_arr_s[tap_q]};
    prod_ext_s = {{(ACC_W-2*DATA_W){1'b0}}, prod_s};
  end

  // Sequencing FSM; all outputs are derived from the next state so they leave flops.
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    win_d   = win_q;
    acc_d   = acc_q;
    in_d    = in_q;
    filt_d  = filt_q;
    data_d  = data_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
        else       state_d = S_IDLE;
      end
      S_LOAD: begin
        in_d    = in_flat;
        filt_d  = filt_flat;
        win_d   = 2'd0;
        tap_d   = 4'd0;
        state_d = S_MAC;
      end
      S_MAC: begin
        if (tap_q == 4'd0) acc_d = prod_ext_s;
        else               acc_d = acc_q + prod_ext_s;
        if (tap_q == 4'd8) begin
          data_d  = acc_d;
          idx_d   = win_q;
          tap_d   = 4'd0;
          state_d = S_OUT;
        end else begin
          tap_d   = tap_q + 4'd1;
        end
      end
      S_OUT: begin
        if (result_ready) begin
          if (win_q == 2'd3) begin
            state_d = S_DONE;
          end else begin
            win_d   = win_q + 2'd1;
            tap_d   = 4'd0;
            state_d = S_MAC;
          end
        end else begin
          state_d = S_OUT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    valid_d = (state_d == S_OUT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tap_q   <= 4'd0;
      win_q   <= 2'd0;
      acc_q   <= {ACC_W{1'b0}};
      in_q    <= {(16*DATA_W){1'b0}};
      filt_q  <= {(9*DATA_W){1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= {ACC_W{1'b0}};
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      win_q   <= win_d;
      acc_q   <= acc_d;
      in_q    <= in_d;
      filt_q  <= filt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign result_valid = valid_q;
  assign result_data  = data_q;
  assign result_idx   = idx_q;

`ifdef CONV_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of offered-but-not-accepted result cycles, restarted per run.
  always_comb begin
    if (state_q == S_LOAD) begin
      stall_cnt_d = 16'd0;
    end else if (valid_q && !result_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= 16'd0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: vector table plus hand-written corner sequences against a reference model.
module tb_conv_sequencer;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] in_flat;
  logic [71:0]  filt_flat;
  logic         busy;
  logic         done;
  logic         result_valid;
  logic         result_ready;
  logic [19:0]  result_data;
  logic [1:0]   result_idx;
`ifdef CONV_STALL_CNT_EN
  logic [15:0]  stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  conv_sequencer #(.DATA_W(8), .ACC_W(20)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .in_flat(in_flat),
    .filt_flat(filt_flat),
    .busy(busy),
    .done(done),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .result_data(result_data),
    .result_idx(result_idx)
`ifdef CONV_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0]      in;
    logic [71:0]       filt;
    logic [3:0][19:0]  exp;
    int                mode;      // 0: ready high, 1: 5-cycle stall on window 1, 2: random ready
    int                exp_done;  // -1: not fixed
  } vec_t;

  // Plain 3x3 valid convolution straight from the definition.
  function automatic logic [19:0] conv_ref(input logic [127:0] im, input logic [71:0] f, input int w);
    int s;
    s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += int'(im[((w / 2 + i) * 4 + (w % 2) + j) * 8 +: 8]) * int'(f[(3 * i + j) * 8 +: 8]);
    return s[19:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // disturb: 0 none, 1 zero inputs + start during MAC of window 0, 2 reset during MAC of window 2, 3 start in DONE
  task automatic run_conv(input vec_t v, input int disturb, output int done_at);
    int  exp_w, nxt_valid, exp_done_c, stalls;
    bit  fin, exp_valid, exp_dn, exp_busy;
    in_flat   = v.in;
    filt_flat = v.filt;
    @(negedge clk);
    start = 1'b1;
    result_ready = 1'b1;
    exp_w = 0; nxt_valid = 11; exp_done_c = -1; stalls = 0; fin = 1'b0; done_at = -1;
    for (int c = 1; c < 300 && !fin; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (disturb == 2 && c == 26) begin
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", result_valid, 0);
        check("rst_data", result_data, 0);
        check("rst_idx", result_idx, 0);
        rst = 1'b0;
        fin = 1'b1;
      end else begin
        exp_valid = (c == nxt_valid);
        exp_dn    = (c == exp_done_c);
        exp_busy  = (exp_done_c < 0) || (c <= exp_done_c);
        if (done && done_at < 0) done_at = c;
        check($sformatf("busy@%0d", c), busy, exp_busy);
        check($sformatf("done@%0d", c), done, exp_dn);
        check($sformatf("valid@%0d", c), result_valid, exp_valid);
        if (exp_valid) begin
          check($sformatf("data@%0d", c), result_data, v.exp[exp_w]);
          check($sformatf("idx@%0d", c), result_idx, exp_w);
        end
        if (exp_done_c >= 0 && c == exp_done_c + 1) begin
          fin = 1'b1;
`ifdef CONV_STALL_CNT_EN
          check("stall_cnt", stall_cnt, stalls);
`endif
        end
        case (v.mode)
          1:       result_ready = !(exp_valid && exp_w == 1 && stalls < 5);
          2:       result_ready = ($urandom_range(0, 3) != 0);
          default: result_ready = 1'b1;
        endcase
        if (exp_valid) begin
          if (result_ready) begin
            if (exp_w == 3) exp_done_c = c + 1;
            else begin exp_w++; nxt_valid = c + 10; end
          end else begin
            stalls++;
            nxt_valid = c + 1;
          end
        end
        if (disturb == 1 && c == 5) begin
          in_flat = 128'd0;
          start = 1'b1;
        end
        if (disturb == 2 && c == 25) rst = 1'b1;
        if (disturb == 3 && c == exp_done_c) start = 1'b1;
      end
    end
    if (!fin) begin
      n_checks++;
      n_errors++;
      $display("FAIL run_timeout: got no completion expected done within budget");
    end
    result_ready = 1'b1;
  endtask

  vec_t vecs[6];
  vec_t gold;
  int   done_at;
  logic [127:0] rin;
  logic [95:0]  rf;

  initial begin
    rst = 1'b1; start = 1'b1; result_ready = 1'b1; in_flat = 128'd0; filt_flat = 72'd0;

    gold.in   = {8'd64, 8'd21, 8'd227, 8'd59, 8'd106, 8'd215, 8'd73, 8'd49,
                 8'd246, 8'd115, 8'd225, 8'd41, 8'd135, 8'd174, 8'd224, 8'd112};
    gold.filt = {8'd177, 8'd113, 8'd184, 8'd144, 8'd191, 8'd89, 8'd210, 8'd87, 8'd70};
    gold.exp  = {20'd195710, 20'd136083, 20'd193071, 20'd182372};
    gold.mode = 0;
    gold.exp_done = 42;

    vecs[0] = gold;
    vecs[1] = gold; vecs[1].mode = 1; vecs[1].exp_done = 47;
    vecs[2].in = {128{1'b1}}; vecs[2].filt = {72{1'b1}};
    vecs[2].exp = {20'd585225, 20'd585225, 20'd585225, 20'd585225};
    vecs[2].mode = 0; vecs[2].exp_done = 42;
    for (int k = 3; k < 6; k++) begin
      rin = {$urandom, $urandom, $urandom, $urandom};
      rf  = {$urandom, $urandom, $urandom};
      vecs[k].in = rin;
      vecs[k].filt = rf[71:0];
      for (int w = 0; w < 4; w++) vecs[k].exp[w] = conv_ref(rin, rf[71:0], w);
      vecs[k].mode = (k == 3) ? 0 : 2;
      vecs[k].exp_done = (k == 3) ? 42 : -1;
    end

    // Reset held with start high: nothing moves.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst0_busy", busy, 0);
      check("rst0_done", done, 0);
      check("rst0_valid", result_valid, 0);
      check("rst0_data", result_data, 0);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    for (int k = 0; k < 6; k++) begin
      run_conv(vecs[k], 0, done_at);
      if (vecs[k].exp_done >= 0) check($sformatf("done_cycle_v%0d", k), done_at, vecs[k].exp_done);
    end

    run_conv(gold, 1, done_at);
    check("iso_done_cycle", done_at, 42);

    run_conv(gold, 2, done_at);
    run_conv(gold, 0, done_at);
    check("post_rst_done_cycle", done_at, 42);

    run_conv(gold, 3, done_at);
    @(negedge clk);
    check("start_in_done_ignored", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
